izh_neuron_array: RTL and testbench

//  Time-multiplexed array of N Izhikevich neurons sharing one update datapath.
//  Per-neuron state (v,u) and params (a,b,c,d) live in register files; one neuron updated per cycle.
//  A step_start pulse sweeps all N neurons; spike vector and done pulse report the step result.

---
 rtl/izh_pkg.sv | 49 ++++
 rtl/izh_neuron_array_core.sv | 60 ++++++
 rtl/izh_neuron_array.sv | 171 +++++++++++++++++
 tb/tb_izh_neuron_array.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared types, constants and helpers for the Izhikevich neuron array.
// Fixed-point constants are functions of FRAC so every instance scales consistently.
package izh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } prm_sel_e;

  localparam logic signed [7:0] DEF_A = 8'sd2;
  localparam logic signed [7:0] DEF_B = 8'sd51;
  localparam logic signed [7:0] DEF_C = -8'sd65;
  localparam logic signed [7:0] DEF_D = 8'sd8;

  // Wide enough for v*v and a*(b*v) products at any legal V_W.
  localparam int CW = 48;
  typedef logic signed [CW-1:0] wide_t;

  function automatic wide_t v_rest(input int frac);
    return wide_t'(-70) <<< frac;
  endfunction

  function automatic wide_t v_thresh(input int frac);
    return wide_t'(30) <<< frac;
  endfunction

  function automatic wide_t const_140(input int frac);
    return wide_t'(140) <<< frac;
  endfunction

  function automatic wide_t saturate(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/izh_neuron_array_core.sv
// Combinational Izhikevich update for one neuron: (v,u,a,b,c,d,stim) -> (v',u',spike).
// hold_v freezes v integration (used by the optional refractory feature).
module izh_update_core
  import izh_pkg::*;
#(
  parameter int V_W    = 16,
  parameter int FRAC   = 7,
  parameter int STIM_W = 8
) (
  input  logic signed [V_W-1:0]    v,
  input  logic signed [V_W-1:0]    u,
  input  logic signed [7:0]        a,
  input  logic signed [7:0]        b,
  input  logic signed [7:0]        c,
  input  logic signed [7:0]        d,
  input  logic        [STIM_W-1:0] stim,
  input  logic                     hold_v,
  output logic signed [V_W-1:0]    v_nxt,
  output logic signed [V_W-1:0]    u_nxt,
  output logic                     spike
);

  localparam wide_t V_THRESH_W = v_thresh(FRAC);
  localparam wide_t C140_W     = const_140(FRAC);

  wide_t vw, uw, vsq, bv;
  wide_t dv, du, dv_s, du_s;
  wide_t v_int, u_int, u_spk;

  assign vw  = wide_t'(v);
  assign uw  = wide_t'(u);
  assign vsq = vw * vw;

  assign dv = (vsq >>> (FRAC + 5)) + (vsq >>> (FRAC + 7)) + (vw <<< 2) + vw
            + C140_W - uw + (wide_t'(stim) <<< FRAC);
  assign bv = (wide_t'(b) * vw) >>> 2;
  assign du = (wide_t'(a) * (bv - (uw <<< 3))) >>> 6;

  // Increments are clamped before the >>>3 step as well as after the add.
  assign dv_s  = saturate(dv, V_W);
  assign du_s  = saturate(du, V_W);
  assign v_int = saturate(vw + (dv_s >>> 3), V_W);
  assign u_int = saturate(uw + (du_s >>> 3), V_W);
  assign u_spk = saturate(uw + (wide_t'(d) <<< 3), V_W);

  assign spike = vw >= V_THRESH_W;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    v_nxt = V_W'(v_int);
    u_nxt = V_W'(u_int);
    if (spike) begin
      v_nxt = V_W'(wide_t'(c) <<< FRAC);
      u_nxt = V_W'(u_spk);
    end else if (hold_v) begin
      v_nxt = v;
    end
  end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one izh_update_core.
// Optional build macro IZH_REFRACTORY_EN adds a per-neuron refractory counter.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int V_W       = 16,
  parameter int FRAC      = 7,
  parameter int STIM_W    = 8,
  parameter int MEM_SHIFT = 1,
  localparam int AW       = $clog2(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_start,
  input  logic [N_NEURONS*STIM_W-1:0]   stim_in,
  input  logic                          prm_wr,
  input  logic [AW-1:0]                 prm_addr,
  input  logic [1:0]                    prm_sel,
  input  logic [7:0]                    prm_data,
  output logic                          busy,
  output logic                          step_done,
  output logic [N_NEURONS-1:0]          spike_vec,
  input  logic [AW-1:0]                 mem_addr,
  output logic [7:0]                    membrane_out
);

  localparam wide_t                 V_REST_W   = v_rest(FRAC);
  localparam wide_t                 V_THRESH_W = v_thresh(FRAC);
  localparam logic signed [V_W-1:0] V_REST     = V_W'(V_REST_W);
  localparam logic [AW:0]           N_EXT      = (AW + 1)'(N_NEURONS);

  state_e                    state_q, state_d;
  logic [AW-1:0]             idx_q;
  logic                      last;
  logic [N_NEURONS*STIM_W-1:0] stim_q;
  logic [N_NEURONS-1:0]      shadow_q, shadow_upd;

  logic signed [V_W-1:0] v_r [N_NEURONS];
  logic signed [V_W-1:0] u_r [N_NEURONS];
  logic signed [7:0]     a_r [N_NEURONS];
  logic signed [7:0]     b_r [N_NEURONS];
  logic signed [7:0]     c_r [N_NEURONS];
  logic signed [7:0]     d_r [N_NEURONS];

  logic signed [V_W-1:0] v_nxt, u_nxt;
  logic                  spike, hold_v;

  assign last      = idx_q == AW'(N_NEURONS - 1);
  assign busy      = state_q != ST_IDLE;
  assign step_done = state_q == ST_DONE;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (step_start) state_d = ST_SWEEP;
      ST_SWEEP: if (last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_upd        = shadow_q;
    shadow_upd[idx_q] = spike;
  end

  // spike_vec is loaded on the final sweep edge so it is already valid while step_done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      stim_q    <= '0;
      shadow_q  <= '0;
      spike_vec <= '0;
    end else begin
      if (state_q == ST_IDLE && step_start) begin
        idx_q    <= '0;
        stim_q   <= stim_in;
        shadow_q <= '0;
      end else if (state_q == ST_SWEEP) begin
        shadow_q <= shadow_upd;
        idx_q    <= last ? '0 : idx_q + AW'(1);
        if (last) spike_vec <= shadow_upd;
      end
    end
  end

  izh_update_core #(.V_W(V_W), .FRAC(FRAC), .STIM_W(STIM_W)) u_core (
    .v      (v_r[idx_q]),
    .u      (u_r[idx_q]),
    .a      (a_r[idx_q]),
    .b      (b_r[idx_q]),
    .c      (c_r[idx_q]),
    .d      (d_r[idx_q]),
    .stim   (stim_q[idx_q*STIM_W +: STIM_W]),
    .hold_v (hold_v),
    .v_nxt  (v_nxt),
    .u_nxt  (u_nxt),
    .spike  (spike)
  );

  // NOTE: these register files are reset element-wise because reset must restore every neuron.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_r[i] <= V_REST;
        u_r[i] <= '0;
      end
    end else if (state_q == ST_SWEEP) begin
      v_r[idx_q] <= v_nxt;
      u_r[idx_q] <= u_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        a_r[i] <= DEF_A;
        b_r[i] <= DEF_B;
        c_r[i] <= DEF_C;
        d_r[i] <= DEF_D;
      end
    end else if (prm_wr && ({1'b0, prm_addr} < N_EXT)) begin
      unique case (prm_sel_e'(prm_sel))
        SEL_A: a_r[prm_addr] <= prm_data;
        SEL_B: b_r[prm_addr] <= prm_data;
        SEL_C: c_r[prm_addr] <= prm_data;
        SEL_D: d_r[prm_addr] <= prm_data;
      endcase
    end
  end

`ifdef IZH_REFRACTORY_EN
  logic [3:0] refr_r [N_NEURONS];

  assign hold_v = refr_r[idx_q] != 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) refr_r[i] <= 4'd0;
    end else if (state_q == ST_SWEEP) begin
      if (spike)       refr_r[idx_q] <= 4'd3;
      else if (hold_v) refr_r[idx_q] <= refr_r[idx_q] - 4'd1;
    end
  end
`else
  assign hold_v = 1'b0;
`endif

  logic signed [V_W-1:0] mem_v;
  wide_t                 mem_diff;

  always_comb begin
    membrane_out = 8'd0;
    mem_v        = v_r[mem_addr];
    mem_diff     = (wide_t'(mem_v) - V_REST_W) >>> MEM_SHIFT;
    if ({1'b0, mem_addr} < N_EXT) begin
      if (wide_t'(mem_v) >= V_THRESH_W)  membrane_out = 8'hFF;
      else if (mem_diff[CW-1])           membrane_out = 8'd0;
      else if (mem_diff > wide_t'(255))  membrane_out = 8'hFF;
      else                               membrane_out = mem_diff[7:0];
    end
  end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Scoreboard bench for izh_neuron_array: a behavioural model predicts each step's spikes and
// membrane readouts; a monitor pops expected spike vectors whenever step_done is seen.
module tb_izh_neuron_array;

  localparam int N      = 8;
  localparam int SCALE  = 128;
  localparam longint V_REST_M = -70 * SCALE;
  localparam longint V_THR_M  = 30 * SCALE;

  logic           clk = 1'b0;
  logic           reset;
  logic           step_start;
  logic [N*8-1:0] stim_in;
  logic           prm_wr;
  logic [2:0]     prm_addr;
  logic [1:0]     prm_sel;
  logic [7:0]     prm_data;
  logic           busy;
  logic           step_done;
  logic [N-1:0]   spike_vec;
  logic [2:0]     mem_addr;
  logic [7:0]     membrane_out;

  izh_neuron_array dut (
    .clk          (clk),
    .reset        (reset),
    .step_start   (step_start),
    .stim_in      (stim_in),
    .prm_wr       (prm_wr),
    .prm_addr     (prm_addr),
    .prm_sel      (prm_sel),
    .prm_data     (prm_data),
    .busy         (busy),
    .step_done    (step_done),
    .spike_vec    (spike_vec),
    .mem_addr     (mem_addr),
    .membrane_out (membrane_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  longint mv [N];
  longint mu [N];
  longint ma [N], mb [N], mc [N], md [N];
  int     mref [N];
  logic [N-1:0] exp_q [$];

  function automatic longint sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = V_REST_M; mu[i] = 0; mref[i] = 0;
      ma[i] = 2; mb[i] = 51; mc[i] = -65; md[i] = 8;
    end
  endfunction

  function automatic void model_prm(input int addr, input int sel, input int data);
    longint s;
    s = longint'($signed(8'(data)));
    case (sel)
      0: ma[addr] = s;
      1: mb[addr] = s;
      2: mc[addr] = s;
      default: md[addr] = s;
    endcase
  endfunction

  function automatic logic [N-1:0] model_step(input int st [N]);
    logic [N-1:0] sp;
    longint v, u, dv, du;
    bit hold;
    sp = '0;
    for (int i = 0; i < N; i++) begin
      v = mv[i];
      u = mu[i];
      hold = 0;
`ifdef IZH_REFRACTORY_EN
      hold = (mref[i] != 0);
`endif
      if (v >= V_THR_M) begin
        sp[i] = 1'b1;
        mv[i] = mc[i] * SCALE;
        mu[i] = sat16(u + md[i] * 8);
        mref[i] = 3;
      end else begin
        dv = sat16((v * v >>> 12) + (v * v >>> 14) + 5 * v + 140 * SCALE - u + st[i] * SCALE);
        du = sat16((ma[i] * ((mb[i] * v >>> 2) - u * 8)) >>> 6);
        mu[i] = sat16(u + (du >>> 3));
        mv[i] = hold ? v : sat16(v + (dv >>> 3));
        if (mref[i] > 0) mref[i]--;
      end
    end
    return sp;
  endfunction

  function automatic longint exp_mem(input longint v);
    longint dlt;
    if (v >= V_THR_M) return 255;
    dlt = (v - V_REST_M) >>> 1;
    if (dlt < 0)   return 0;
    if (dlt > 255) return 255;
    return dlt;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && step_done) begin
      if (exp_q.size() == 0) begin
        check("done_without_step", {63'd0, step_done}, 0);
      end else begin
        check("spike_vec", {56'd0, spike_vec}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_mem(input string tag);
    for (int i = 0; i < N; i++) begin
      mem_addr = 3'(i);
      #1;
      check($sformatf("%s_mem%0d", tag, i), {56'd0, membrane_out}, exp_mem(mv[i]));
    end
  endtask

  task automatic write_prm(input int addr, input int sel, input int data);
    prm_wr = 1'b1; prm_addr = 3'(addr); prm_sel = 2'(sel); prm_data = 8'(data);
    tick();
    prm_wr = 1'b0;
    model_prm(addr, sel, data);
  endtask

  // One full step; optionally pokes step_start mid-sweep and writes a param while neuron 0 updates.
  task automatic do_step(input int st [N], input bit poke, input bit pwr,
                         input int paddr, input int psel, input int pdata, input bit timing);
    int cnt;
    for (int i = 0; i < N; i++) stim_in[i*8 +: 8] = 8'(st[i]);
    step_start = 1'b1;
    exp_q.push_back(model_step(st));
    tick();
    step_start = 1'b0;
    if (timing) check("busy_after_start", {63'd0, busy}, 1);
    cnt = 1;
    while (step_done !== 1'b1 && cnt < 40) begin
      prm_wr     = pwr && cnt == 1;
      prm_addr   = 3'(paddr); prm_sel = 2'(psel); prm_data = 8'(pdata);
      step_start = poke && cnt == 3;
      tick();
      cnt++;
    end
    prm_wr = 1'b0;
    step_start = 1'b0;
    if (pwr) model_prm(paddr, psel, pdata);
    check("step_done_seen", {63'd0, step_done}, 1);
    if (timing) check("start_to_done_cycles", cnt, N + 1);
    tick();
    check("idle_after_done", {63'd0, busy}, 0);
    check_all_mem("step");
  endtask

  int st [N];
  int steps;
  bit seen;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; step_start = 1'b0; stim_in = '0; prm_wr = 1'b0;
    prm_addr = '0; prm_sel = '0; prm_data = '0; mem_addr = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check("reset_busy", {63'd0, busy}, 0);
    check("reset_step_done", {63'd0, step_done}, 0);
    check("reset_spike_vec", {56'd0, spike_vec}, 0);
    for (int i = 0; i < N; i++) begin
      mem_addr = 3'(i);
      #1;
      check($sformatf("reset_mem%0d", i), {56'd0, membrane_out}, 0);
    end

    // random stimulus, random params, timing checks and an ignored busy start
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) st[i] = int'($urandom_range(0, 255));
      if (k == 2) write_prm(int'($urandom_range(0, 7)), 0, int'($urandom_range(1, 6)));
      if (k == 3) write_prm(int'($urandom_range(0, 7)), 1, int'($urandom_range(20, 60)));
      do_step(st, k == 0 || k == 4, k == 1, 0, 1, 30, 1);
    end

    // neuron 3 driven alone from reset until it spikes
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    for (int i = 0; i < N; i++) st[i] = 0;
    st[3] = 200;
    seen = 0; steps = 0;
    while (!seen && steps < 60) begin
      do_step(st, 0, 0, 0, 0, 0, 0);
      seen = exp_q.size() == 0 && mv[3] == mc[3] * SCALE;
      steps++;
    end
    check("neuron3_spiked", {63'd0, seen}, 1);
    check("neuron3_reset_v", mv[3], -65 * SCALE);
    do_step(st, 0, 0, 0, 0, 0, 0);
    do_step(st, 0, 0, 0, 0, 0, 0);

    // new c/d for neuron 3: c=-69 gives a readout of 64 after reset, distinct from the default
    write_prm(3, 2, -69);
    write_prm(3, 3, 40);
    write_prm(5, 2, -50);
    st[5] = 180;
    seen = 0; steps = 0;
    while (!seen && steps < 60) begin
      do_step(st, 0, 0, 0, 0, 0, 0);
      seen = mv[3] == -69 * SCALE;
      steps++;
    end
    check("neuron3_new_c_spike", {63'd0, seen}, 1);
    mem_addr = 3'd3;
    #1;
    check("neuron3_mem_after_c", {56'd0, membrane_out}, 64);
    for (int k = 0; k < 5; k++) do_step(st, 0, 0, 0, 0, 0, 0);

    // reset while neuron 4 is being updated: no step_done, everything back to rest
    for (int i = 0; i < N; i++) stim_in[i*8 +: 8] = 8'd250;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midreset_busy", {63'd0, busy}, 0);
    check("midreset_done", {63'd0, step_done}, 0);
    check_all_mem("midreset");
    repeat (12) tick();

    for (int i = 0; i < N; i++) st[i] = int'($urandom_range(0, 255));
    do_step(st, 0, 0, 0, 0, 0, 1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
